// File: rtl/pconv_feeder_c1.sv
// Stream sequencer for the conv-1 pointwise unit: walks channels x pixels, fetching image and coefficient data.
// Optional output tag delay line enabled by defining PCONV_FEEDER_TAG_EN.
module pconv_feeder_c1 #(
  parameter int N        = 16,
  parameter int IMG_SIZE = 28,
  parameter int ADDR_W   = 10,
  parameter int OUT_CH   = 6,
  parameter int OC_W     = 3,
  parameter int MULT_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  input  logic [4:0]        shift_cfg,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [N-1:0]      img_rdata,
  output logic [OC_W-1:0]   w_addr,
  input  logic [N-1:0]      w_rdata,
  input  logic [31:0]       b_rdata,
  output logic              ce,
  output logic              input_vld,
  output logic [N-1:0]      input_din,
  output logic [N-1:0]      weight_din,
  output logic [31:0]       bias_din,
  output logic [4:0]        shift_din,
  output logic              tag_vld,
  output logic [OC_W-1:0]   tag_ch,
  output logic [ADDR_W-1:0] tag_pix,
  output logic              tag_last
);

  localparam int PIX   = IMG_SIZE * IMG_SIZE;
  localparam int DEPTH = MULT_LAT + 1;
  localparam int DW    = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] PIX_LAST   = ADDR_W'(PIX - 1);
  localparam logic [OC_W-1:0]   CH_LAST    = OC_W'(OUT_CH - 1);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_pix;
  logic [OC_W-1:0]   r_ch;
  logic [DW-1:0]     r_drain;
  logic              r_after_load;
  logic              r_vld_p1;
  logic [N-1:0]      r_weight;
  logic [31:0]       r_bias;
  logic [4:0]        r_shift;
  logic              w_accept;
  logic              w_issue;
  logic              w_last_pix;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_issue    = (r_state == S_STREAM) && !hold;
  assign w_last_pix = w_issue && (r_pix == PIX_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD;
      S_LOAD:   w_next = S_STREAM;
      S_STREAM: if (w_last_pix) w_next = (r_ch == CH_LAST) ? S_DRAIN : S_LOAD;
      S_DRAIN:  if (r_drain == DRAIN_LAST) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    w_addr   = '0;
    img_addr = '0;
    case (r_state)
      S_LOAD: begin
        busy   = 1'b1;
        w_addr = r_ch;
      end
      S_STREAM: begin
        busy     = 1'b1;
        img_addr = r_pix;
      end
      S_DRAIN: begin
        busy = 1'b1;
        done = (r_drain == DRAIN_LAST);
      end
      default: ;
    endcase
  end

  assign ce = busy;

  // issue stage: counters advance on every read that leaves the sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix        <= '0;
      r_ch         <= '0;
      r_drain      <= '0;
      r_after_load <= 1'b0;
      r_vld_p1     <= 1'b0;
    end else begin
      r_after_load <= (r_state == S_LOAD);
      r_vld_p1     <= w_issue;
      r_drain      <= (r_state == S_DRAIN) ? r_drain + 1'b1 : '0;
      if (w_accept) begin
        r_pix <= '0;
        r_ch  <= '0;
      end else if (w_issue) begin
        r_pix <= w_last_pix ? '0 : r_pix + 1'b1;
        if (w_last_pix && (r_ch != CH_LAST)) r_ch <= r_ch + 1'b1;
      end
    end
  end

  // coefficient stage: ROM data lands one cycle after LOAD, held for the whole channel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_weight <= '0;
      r_bias   <= '0;
      r_shift  <= '0;
    end else begin
      if (w_accept) r_shift <= shift_cfg;
      if ((r_state == S_STREAM) && r_after_load) begin
        r_weight <= w_rdata;
        r_bias   <= b_rdata;
      end
    end
  end

  assign input_vld  = r_vld_p1;
  assign input_din  = r_vld_p1 ? img_rdata : '0;
  assign weight_din = r_weight;
  assign bias_din   = r_bias;
  assign shift_din  = r_shift;

`ifdef PCONV_FEEDER_TAG_EN
  logic [OC_W-1:0]               r_ch_p1;
  logic [ADDR_W-1:0]             r_pix_p1;
  logic                          r_last_p1;
  logic [DEPTH-1:0]              r_tvld_p2;
  logic [DEPTH-1:0][OC_W-1:0]    r_tch_p2;
  logic [DEPTH-1:0][ADDR_W-1:0]  r_tpix_p2;
  logic [DEPTH-1:0]              r_tlast_p2;

  // tag stage: fields zeroed for idle slots so the line never shows stale indices
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch_p1    <= '0;
      r_pix_p1   <= '0;
      r_last_p1  <= 1'b0;
      r_tvld_p2  <= '0;
      r_tch_p2   <= '0;
      r_tpix_p2  <= '0;
      r_tlast_p2 <= '0;
    end else begin
      r_ch_p1       <= w_issue ? r_ch : '0;
      r_pix_p1      <= w_issue ? r_pix : '0;
      r_last_p1     <= w_last_pix;
      r_tvld_p2[0]  <= r_vld_p1;
      r_tch_p2[0]   <= r_ch_p1;
      r_tpix_p2[0]  <= r_pix_p1;
      r_tlast_p2[0] <= r_last_p1;
      for (int i = 1; i < DEPTH; i++) begin
        r_tvld_p2[i]  <= r_tvld_p2[i-1];
        r_tch_p2[i]   <= r_tch_p2[i-1];
        r_tpix_p2[i]  <= r_tpix_p2[i-1];
        r_tlast_p2[i] <= r_tlast_p2[i-1];
      end
    end
  end

  assign tag_vld  = r_tvld_p2[DEPTH-1];
  assign tag_ch   = r_tch_p2[DEPTH-1];
  assign tag_pix  = r_tpix_p2[DEPTH-1];
  assign tag_last = r_tlast_p2[DEPTH-1];
`else
  assign tag_vld  = 1'b0;
  assign tag_ch   = '0;
  assign tag_pix  = '0;
  assign tag_last = 1'b0;
`endif

endmodule

// File: tb/tb_pconv_feeder_c1.sv
// Directed bench for pconv_feeder_c1 at IMG_SIZE=2, OUT_CH=2, MULT_LAT=2.
module tb_pconv_feeder_c1;
  localparam int N = 16, IMG = 2, AW = 2, OCH = 2, OCW = 1, ML = 2, NC = 26;

  logic          clk = 1'b0;
  logic          rst, start, hold;
  logic [4:0]    shift_cfg;
  logic          busy, done, ce, input_vld, tag_vld, tag_last;
  logic [AW-1:0] img_addr, tag_pix;
  logic [OCW-1:0] w_addr, tag_ch;
  logic [N-1:0]  img_rdata, w_rdata, input_din, weight_din;
  logic [31:0]   b_rdata, bias_din;
  logic [4:0]    shift_din;

  always #5 clk = ~clk;

  pconv_feeder_c1 #(.N(N), .IMG_SIZE(IMG), .ADDR_W(AW), .OUT_CH(OCH), .OC_W(OCW), .MULT_LAT(ML)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .shift_cfg(shift_cfg),
    .busy(busy), .done(done), .img_addr(img_addr), .img_rdata(img_rdata),
    .w_addr(w_addr), .w_rdata(w_rdata), .b_rdata(b_rdata), .ce(ce),
    .input_vld(input_vld), .input_din(input_din), .weight_din(weight_din),
    .bias_din(bias_din), .shift_din(shift_din), .tag_vld(tag_vld),
    .tag_ch(tag_ch), .tag_pix(tag_pix), .tag_last(tag_last)
  );

  function automatic logic [15:0] img_val(input int i);
    return 16'(16'h1A00 + i * 37);
  endfunction
  function automatic logic [15:0] w_val(input int c);
    return (c != 0) ? 16'hB3C1 : 16'h7E05;
  endfunction
  function automatic logic [31:0] b_val(input int c);
    return (c != 0) ? 32'hFFFF_8123 : 32'h0001_2345;
  endfunction

  // memories with one-cycle read latency
  always @(posedge clk) begin
    img_rdata <= img_val(int'(img_addr));
    w_rdata   <= w_val(int'(w_addr));
    b_rdata   <= b_val(int'(w_addr));
  end

  localparam int S_BUSY = 0, S_CE = 1, S_DONE = 2, S_VLD = 3, S_DIN = 4, S_W = 5, S_B = 6,
                 S_SH = 7, S_IA = 8, S_WA = 9, S_TV = 10, S_TC = 11, S_TP = 12, S_TL = 13;
  logic [31:0] tr [NC][14];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, k, act, exp);
    end
  endtask

  task automatic snap(input int k);
    tr[k][S_BUSY] = 32'(busy);      tr[k][S_CE] = 32'(ce);          tr[k][S_DONE] = 32'(done);
    tr[k][S_VLD]  = 32'(input_vld); tr[k][S_DIN] = 32'(input_din);  tr[k][S_W] = 32'(weight_din);
    tr[k][S_B]    = bias_din;       tr[k][S_SH] = 32'(shift_din);   tr[k][S_IA] = 32'(img_addr);
    tr[k][S_WA]   = 32'(w_addr);    tr[k][S_TV] = 32'(tag_vld);     tr[k][S_TC] = 32'(tag_ch);
    tr[k][S_TP]   = 32'(tag_pix);   tr[k][S_TL] = 32'(tag_last);
  endtask

  typedef struct {
    string nm;
    int st0, st1, hlo, hhi, rstc, swc;
    int chk_lo, quiet_lo, quiet_hi;
    int done_c, busy_lo;
  } scen_t;

  typedef struct {
    int sc;
    int cyc;
    int sig;
    logic [31:0] exp;
    string nm;
  } pt_t;

  scen_t sc [4];
  int    vcs [4][8];
  pt_t   pts [12];

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; shift_cfg = 5'd0;

    sc[0] = '{nm:"basic", st0:0, st1:-1, hlo:-1, hhi:-1, rstc:-1, swc:4, chk_lo:0, quiet_lo:-1, quiet_hi:-1, done_c:14, busy_lo:1};
    sc[1] = '{nm:"hold",  st0:0, st1:-1, hlo:3,  hhi:4,  rstc:-1, swc:4, chk_lo:0, quiet_lo:-1, quiet_hi:-1, done_c:16, busy_lo:1};
    sc[2] = '{nm:"ign",   st0:0, st1:7,  hlo:-1, hhi:-1, rstc:-1, swc:4, chk_lo:0, quiet_lo:-1, quiet_hi:-1, done_c:14, busy_lo:1};
    sc[3] = '{nm:"rst",   st0:0, st1:8,  hlo:-1, hhi:-1, rstc:5,  swc:12, chk_lo:6, quiet_lo:6, quiet_hi:7, done_c:22, busy_lo:9};
    vcs[0] = '{3, 4, 5, 6, 8, 9, 10, 11};
    vcs[1] = '{3, 6, 7, 8, 10, 11, 12, 13};
    vcs[2] = '{3, 4, 5, 6, 8, 9, 10, 11};
    vcs[3] = '{11, 12, 13, 14, 16, 17, 18, 19};

    pts[0]  = '{0, 2,  S_IA, 32'd0, "img_addr"};
    pts[1]  = '{0, 3,  S_IA, 32'd1, "img_addr"};
    pts[2]  = '{0, 4,  S_IA, 32'd2, "img_addr"};
    pts[3]  = '{0, 5,  S_IA, 32'd3, "img_addr"};
    pts[4]  = '{0, 6,  S_WA, 32'd1, "w_addr_load1"};
    pts[5]  = '{0, 10, S_IA, 32'd3, "img_addr"};
    pts[6]  = '{1, 4,  S_IA, 32'd1, "img_addr_hold"};
    pts[7]  = '{1, 5,  S_IA, 32'd1, "img_addr_hold"};
    pts[8]  = '{1, 6,  S_IA, 32'd2, "img_addr_hold"};
    pts[9]  = '{1, 8,  S_WA, 32'd1, "w_addr_load1"};
    pts[10] = '{3, 10, S_IA, 32'd0, "img_addr_rerun"};
    pts[11] = '{3, 14, S_WA, 32'd1, "w_addr_rerun"};

    repeat (2) @(posedge clk);

    for (int s = 0; s < 4; s++) begin
      // reset and confirm reset state
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      snap(0);
      for (int g = 0; g < 14; g++) chk($sformatf("%s_reset_sig%0d", sc[s].nm, g), 0, tr[0][g], 32'd0);

      for (int k = 0; k < NC; k++) begin
        @(posedge clk); #1;
        start     = (k == sc[s].st0) || (k == sc[s].st1);
        hold      = (k >= sc[s].hlo) && (k <= sc[s].hhi);
        rst       = (k == sc[s].rstc);
        shift_cfg = (k < sc[s].swc) ? 5'd7 : 5'd3;
        @(negedge clk);
        snap(k);
      end
      #1 start = 1'b0; hold = 1'b0; rst = 1'b0;

      for (int k = sc[s].chk_lo; k < NC; k++) begin
        int vi, ti;
        logic e_busy;
        vi = -1; ti = -1;
        for (int i = 0; i < 8; i++) begin
          if (vcs[s][i] == k)      vi = i;
          if (vcs[s][i] + 3 == k)  ti = i;
        end
        e_busy = (k >= sc[s].busy_lo) && (k <= sc[s].done_c);
        chk({sc[s].nm, "_busy"}, k, tr[k][S_BUSY], 32'(e_busy));
        chk({sc[s].nm, "_ce"},   k, tr[k][S_CE],   32'(e_busy));
        chk({sc[s].nm, "_done"}, k, tr[k][S_DONE], 32'(k == sc[s].done_c));
        chk({sc[s].nm, "_vld"},  k, tr[k][S_VLD],  32'(vi >= 0));
        chk({sc[s].nm, "_shift"}, k, tr[k][S_SH], (k >= sc[s].busy_lo) ? 32'd7 : 32'd0);
        if (vi >= 0) begin
          chk({sc[s].nm, "_din"},    k, tr[k][S_DIN], 32'(img_val(vi % 4)));
          chk({sc[s].nm, "_weight"}, k, tr[k][S_W],   32'(w_val(vi / 4)));
          chk({sc[s].nm, "_bias"},   k, tr[k][S_B],   b_val(vi / 4));
        end
        if (k >= sc[s].quiet_lo && k <= sc[s].quiet_hi) begin
          chk({sc[s].nm, "_q_din"},  k, tr[k][S_DIN], 32'd0);
          chk({sc[s].nm, "_q_w"},    k, tr[k][S_W],   32'd0);
          chk({sc[s].nm, "_q_b"},    k, tr[k][S_B],   32'd0);
          chk({sc[s].nm, "_q_ia"},   k, tr[k][S_IA],  32'd0);
          chk({sc[s].nm, "_q_wa"},   k, tr[k][S_WA],  32'd0);
        end
`ifdef PCONV_FEEDER_TAG_EN
        chk({sc[s].nm, "_tag_vld"},  k, tr[k][S_TV], 32'(ti >= 0));
        chk({sc[s].nm, "_tag_ch"},   k, tr[k][S_TC], (ti >= 0) ? 32'(ti / 4) : 32'd0);
        chk({sc[s].nm, "_tag_pix"},  k, tr[k][S_TP], (ti >= 0) ? 32'(ti % 4) : 32'd0);
        chk({sc[s].nm, "_tag_last"}, k, tr[k][S_TL], 32'((ti >= 0) && (ti % 4 == 3)));
`else
        chk({sc[s].nm, "_tag_vld"},  k, tr[k][S_TV], 32'd0);
        chk({sc[s].nm, "_tag_ch"},   k, tr[k][S_TC], 32'd0);
        chk({sc[s].nm, "_tag_pix"},  k, tr[k][S_TP], 32'd0);
        chk({sc[s].nm, "_tag_last"}, k, tr[k][S_TL], 32'd0);
`endif
      end

      for (int p = 0; p < 12; p++) begin
        if (pts[p].sc == s)
          chk({sc[s].nm, "_", pts[p].nm}, pts[p].cyc, tr[pts[p].cyc][pts[p].sig], pts[p].exp);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pconv_feeder_c1.md
# pconv_feeder_c1

Stream sequencer that drives the conv-1 pointwise convolution unit. On `start` it walks every output channel and, within each channel, every pixel of the single-channel input feature map. It fetches pixels from the image RAM and per-channel weight/bias from ROM, then presents them on the unit's `input_vld/input_din/weight_din/bias_din/shift_din` inputs. An optional tag delay line reports the channel and pixel index aligned with the unit's `conv_dout_vld`, for the downstream feature-map writer.

## Interface
- N, 16, data width of pixel and weight
- IMG_SIZE, 28, feature map side; PIX = IMG_SIZE*IMG_SIZE
- ADDR_W, 10, image RAM address width (must satisfy 2^ADDR_W ≥ PIX)
- OUT_CH, 6, number of output channels
- OC_W, 3, channel index width
- MULT_LAT, 2, multiplier latency in cycles; unit output lags input_vld by MULT_LAT+1

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  run request pulse, honoured only in IDLE
- hold  in  1  pause pixel issue (STREAM only)
- shift_cfg  in  5  requantisation shift, latched at start
- busy  out  1  high from cycle after accepted start through done cycle
- done  out  1  one-cycle pulse, coincident with final expected conv_dout_vld
- img_addr  out  ADDR_W  image RAM read address
- img_rdata  in  N  image RAM data, 1-cycle read latency
- w_addr  out  OC_W  weight/bias ROM address
- w_rdata  in  N  weight, 1-cycle latency
- b_rdata  in  32  bias, 1-cycle latency
- ce  out  1  unit enable, equals busy
- input_vld, input_din[N], weight_din[N], bias_din[32], shift_din[5]  out  drive the conv unit
- tag_vld, tag_ch[OC_W], tag_pix[ADDR_W], tag_last  out  output tags

## Operation
- States: IDLE, LOAD, STREAM, DRAIN.
- IDLE: on start, latch shift_cfg into shift_din, clear ch/pix counters, go to LOAD. start is ignored in every other state.
- LOAD, 1 cycle: w_addr = ch. Go to STREAM. hold is ignored in LOAD.
- STREAM: img_addr = pix. A read is issued when hold=0, and pix then increments.
  - In the cycle after LOAD, w_rdata and b_rdata are registered into weight_din and bias_din.
  - After the read of pix = PIX-1: if ch = OUT_CH-1, go to DRAIN; else increment ch and go to LOAD.
- input_vld is asserted the cycle after each issued read, with input_din = img_rdata. A read in flight always completes even if hold rises.
- DRAIN: count MULT_LAT+1 cycles after the last input_vld. Pulse done in the final count cycle, then return to IDLE with busy low.
- weight_din, bias_din and shift_din are stable for every input_vld of a channel. They change only at channel boundaries.
- Counters: pix wraps 0..PIX-1; ch runs 0..OUT_CH-1 and does not wrap within a run.
- rst mid-run: at the next edge, go to IDLE, clear the pipeline and tag line, drive all outputs to reset values. No done is issued.
- Reset values: every output is 0, including shift_din and the tags.

## Timing
- start sampled in cycle 0, LOAD in cycle 1, first STREAM in cycle 2 (img_addr=0), first input_vld in cycle 3.
- With no hold, each channel costs 1+PIX cycles. The next LOAD overlaps the last input_vld of the previous channel.
- Last input_vld at cycle L gives done (and tag_last of the final item) at L+MULT_LAT+1.
- Each hold cycle in STREAM delays all later events by exactly one cycle.

## Configuration
- PCONV_FEEDER_TAG_EN defined: a shift register of depth MULT_LAT+1 carries {vld, ch, pix, last} from each input_vld. tag_vld matches conv_dout_vld; tag_last marks pix = PIX-1.
- Undefined: the tag line is omitted and tag_vld, tag_ch, tag_pix and tag_last are tied to 0. All other behaviour is unchanged.

## Test plan
Parameters for all scenarios: IMG_SIZE=2, OUT_CH=2, MULT_LAT=2.
- Basic run, start at cycle 0:
  - img_addr 0..3 in cycles 2–5; input_vld in cycles 3–6 with w[0]/b[0].
  - LOAD in cycle 6 (w_addr=1); input_vld in cycles 8–11 with w[1]/b[1].
  - done in cycle 14 only; busy high in cycles 1–14.
- Hold: hold=1 in cycles 3–4 → pixel 1 is read in cycle 5; no input_vld in cycles 4–5; done moves to cycle 16.
- start pulsed at cycle 7 during a run → ignored; the same done cycle as the basic run.
- rst at cycle 5 → all outputs 0 from cycle 6 and no done. A fresh start at cycle 8 reproduces the basic sequence shifted by 8.
- With PCONV_FEEDER_TAG_EN: tag_vld in cycles 6–9 and 11–14; tag_pix 0,1,2,3 per channel; tag_ch 0 then 1; tag_last in cycles 9 and 14. Without the macro, all tags stay 0.
- shift_cfg=7 at start, then changed to 3 at cycle 4 → shift_din stays 7 for the whole run.
